// File: rtl/bfy_serializer_128_if.sv
// Butterfly-pair input / serial output bundle for bfy_serializer_128.
// Optional frame_cnt port present only when BFY_SER_FRAME_CNT_EN is defined.
interface bfy_serializer_128_if #(
    parameter int float_len = 32
);
    logic [2*float_len-1:0] data_in1;
    logic [2*float_len-1:0] data_in2;
    logic                   data_in_valid;
    logic [2*float_len-1:0] data_out;
    logic                   data_out_valid;
    logic                   frame_start;
    logic                   overflow;
`ifdef BFY_SER_FRAME_CNT_EN
    logic [15:0]            frame_cnt;
`endif

    modport master (
        output data_in1, data_in2, data_in_valid,
`ifdef BFY_SER_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  data_out, data_out_valid, frame_start, overflow
    );

    modport slave (
        input  data_in1, data_in2, data_in_valid,
`ifdef BFY_SER_FRAME_CNT_EN
        output frame_cnt,
`endif
        output data_out, data_out_valid, frame_start, overflow
    );
endinterface

// File: rtl/bfy_serializer_128.sv
// Serializes 128 butterfly pairs into 256 samples: uppers pass through with 1-cycle latency,
// lowers are buffered then drained back-to-back. BFY_SER_FRAME_CNT_EN adds a completed-frame counter.
module bfy_serializer_128 #(
    parameter int float_len = 32,
    parameter int half_len  = 128,
    parameter int addr_len  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    bfy_serializer_128_if.slave  bus
);
    localparam int                  W    = 2 * float_len;
    localparam logic [addr_len-1:0] LAST = addr_len'(half_len - 1);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [addr_len-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_len-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]        mem [half_len];
    logic [W-1:0]        ram_q;
    logic [W-1:0]        data_out_q;
    logic                rd_vld_q;
    logic                data_out_valid_q;
    logic                frame_start_q;
    logic                overflow_q;

    logic accept;
    logic wr_last;
    logic rd_en;

    assign accept  = bus.data_in_valid && (state_q != DRAIN);
    assign wr_last = accept && (wr_ptr_q == LAST);
    // Address 0 is read in the same cycle as the last write, so the drain follows with no bubble.
    assign rd_en   = wr_last || ((state_q == DRAIN) && (rd_ptr_q != '0));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        case (state_q)
            IDLE:    if (accept) state_d = wr_last ? DRAIN : PASS;
            PASS:    if (wr_last) state_d = DRAIN;
            DRAIN:   if (rd_ptr_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BFY_SER_FRAME_CNT_EN
    logic        rd_last_q;
    logic        out_last_q;
    logic [15:0] frame_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            rd_vld_q         <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_start_q    <= 1'b0;
            overflow_q       <= 1'b0;
`ifdef BFY_SER_FRAME_CNT_EN
            rd_last_q        <= 1'b0;
            out_last_q       <= 1'b0;
            frame_cnt_q      <= '0;
`endif
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            rd_vld_q         <= rd_en;
            data_out_valid_q <= accept || rd_vld_q;
            frame_start_q    <= accept && (state_q == IDLE);
            if (accept)
                data_out_q <= bus.data_in1;
            else if (rd_vld_q)
                data_out_q <= ram_q;
            if (bus.data_in_valid && (state_q == DRAIN))
                overflow_q <= 1'b1;
`ifdef BFY_SER_FRAME_CNT_EN
            rd_last_q  <= rd_en && (rd_ptr_q == LAST);
            out_last_q <= rd_last_q;
            if (out_last_q)
                frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
        end
    end

    // Lower-result buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= bus.data_in2;
        if (rd_en)  ram_q <= mem[rd_ptr_q];
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.frame_start    = frame_start_q;
    assign bus.overflow       = overflow_q;
`ifdef BFY_SER_FRAME_CNT_EN
    assign bus.frame_cnt      = frame_cnt_q;
`endif
endmodule

// File: tb/tb_bfy_serializer_128.sv
// Randomized bench for bfy_serializer_128 against a cycle-scheduled frame model.
module tb_bfy_serializer_128;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bfy_serializer_128_if bus_if ();
    bfy_serializer_128 dut (.clk(clk), .rst(rst), .bus(bus_if));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected output events, indexed by cycle modulo ring size.
    localparam int RING = 512;
    bit          r_vld [RING];
    bit          r_fs  [RING];
    bit          r_fc  [RING];
    logic [63:0] r_dat [RING];

    logic [63:0] lower [$];
    int          cnt;
    int          busy_until;
    int          ovf_at;
    logic [63:0] exp_do;
    int          exp_fc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < RING; i++) begin
            r_vld[i] = 0; r_fs[i] = 0; r_fc[i] = 0; r_dat[i] = '0;
        end
        lower.delete();
        cnt = 0; busy_until = -1000; ovf_at = -1; exp_do = '0; exp_fc = 0;
    endtask

    task automatic check_cycle();
        int s;
        s = cyc % RING;
        if (r_vld[s]) exp_do = r_dat[s];
        if (r_fc[s])  exp_fc = (exp_fc + 1) % 65536;
        check("vld",  64'(bus_if.data_out_valid), 64'(r_vld[s]));
        check("fs",   64'(bus_if.frame_start),    64'(r_fs[s]));
        check("ovf",  64'(bus_if.overflow),       64'((ovf_at >= 0) && (cyc >= ovf_at)));
        check("dout", bus_if.data_out,            exp_do);
`ifdef BFY_SER_FRAME_CNT_EN
        check("fcnt", 64'(bus_if.frame_cnt),      64'(exp_fc));
`endif
        r_vld[s] = 0; r_fs[s] = 0; r_fc[s] = 0;
    endtask

    // Frame rules: uppers at c+1, lowers at T+2+k, busy through T+128, count at T+130.
    task automatic model_in(input bit v, input logic [63:0] a, input logic [63:0] b);
        int c;
        c = cyc;
        if (!v) return;
        if (c <= busy_until) begin
            if (ovf_at < 0) ovf_at = c + 1;
            return;
        end
        r_vld[(c+1)%RING] = 1;
        r_dat[(c+1)%RING] = a;
        r_fs[(c+1)%RING]  = (cnt == 0);
        lower.push_back(b);
        cnt++;
        if (cnt == 128) begin
            for (int k = 0; k < 128; k++) begin
                r_vld[(c+2+k)%RING] = 1;
                r_dat[(c+2+k)%RING] = lower[k];
            end
            r_fc[(c+130)%RING] = 1;
            busy_until = c + 128;
            cnt = 0;
            lower.delete();
        end
    endtask

    task automatic step(input bit v, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
        bus_if.data_in_valid = v;
        bus_if.data_in1      = a;
        bus_if.data_in2      = b;
        model_in(v, a, b);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, rnd64(), rnd64());
    endtask

    task automatic frame(input bit gapped);
        int sent;
        int j;
        sent = 0; j = 0;
        while (sent < 128) begin
            if (gapped && (j % 3 == 2)) step(0, rnd64(), rnd64());
            else begin
                step(1, rnd64(), rnd64());
                sent++;
            end
            j++;
        end
    endtask

    task automatic reset_now();
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
        rst = 1;
        bus_if.data_in_valid = 0;
        #1;
        check("rst_dout", bus_if.data_out, 64'd0);
        check("rst_vld",  64'(bus_if.data_out_valid), 64'd0);
        check("rst_fs",   64'(bus_if.frame_start), 64'd0);
        check("rst_ovf",  64'(bus_if.overflow), 64'd0);
`ifdef BFY_SER_FRAME_CNT_EN
        check("rst_fcnt", 64'(bus_if.frame_cnt), 64'd0);
`endif
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
        rst = 0;
    endtask

    initial begin
        bus_if.data_in_valid = 0;
        bus_if.data_in1 = '0;
        bus_if.data_in2 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("init_dout", bus_if.data_out, 64'd0);
        check("init_vld",  64'(bus_if.data_out_valid), 64'd0);
        check("init_ovf",  64'(bus_if.overflow), 64'd0);
        rst = 0;
        idle(6);

        // Single frame with recognisable values.
        for (int k = 0; k < 128; k++) step(1, 64'(k), 64'(1000 + k));
        idle(140);

        // Gapped frame.
        frame(1);
        idle(140);

        // Three back-to-back frames, next frame starting exactly at T+129.
        for (int f = 0; f < 3; f++) begin
            frame(0);
            idle(128);
        end
        idle(10);

        // Collision at T+50.
        frame(0);
        idle(49);
        step(1, rnd64(), rnd64());
        idle(140);

        // Reset mid-drain at T+60, then a clean frame.
        frame(0);
        idle(59);
        reset_now();
        frame(0);
        idle(140);

        // Random traffic including collisions.
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0, rnd64(), rnd64());
        idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
